// File: rtl/operand_fetch.sv
// Operand fetch stage: a 32x32 register file with writeback port and a registered output stage for ALU operands.
// Define OPFETCH_WB_BYPASS_EN so that a load captures the writeback data when it targets a source register in the same cycle.
module operand_fetch (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        valid_i,
    input  logic        stall_i,
    input  logic        flush_i,
    input  logic [4:0]  RS1addr_i,
    input  logic [4:0]  RS2addr_i,
    input  logic [4:0]  RDaddr_i,
    input  logic [31:0] Imm_i,
    input  logic        ALUSrc_i,
    input  logic [2:0]  ALUCtrl_i,
    input  logic        WBen_i,
    input  logic [4:0]  WBaddr_i,
    input  logic [31:0] WBdata_i,
    output logic        valid_o,
    output logic [31:0] data1_o,
    output logic [31:0] data2_o,
    output logic [2:0]  ALUCtrl_o,
    output logic [4:0]  RDaddr_o
);

    logic [31:0] rf_data [32];
    logic        wb_active;
    logic [31:0] rs1_val;
    logic [31:0] rs2_val;
    logic [31:0] op1_val;
    logic [31:0] op2_val;

    logic        valid_reg, valid_next;
    logic [31:0] data1_reg, data1_next;
    logic [31:0] data2_reg, data2_next;
    logic [2:0]  ctrl_reg, ctrl_next;
    logic [4:0]  rd_reg, rd_next;

    assign wb_active  = WBen_i && (WBaddr_i != 5'd0);
    assign rf_data[0] = 32'd0;

    // x1..x31 are individual flop registers so reset can clear the whole file in one edge.
    generate
        for (genvar gi = 1; gi < 32; gi++) begin : gen_rf
            logic [31:0] q_reg;

            always_ff @(posedge clk_i) begin
                if (rst_i) begin
                    q_reg <= 32'd0;
                end else if (wb_active && (WBaddr_i == 5'(gi))) begin
                    q_reg <= WBdata_i;
                end
            end

            assign rf_data[gi] = q_reg;
        end
    endgenerate

    assign rs1_val = rf_data[RS1addr_i];
    assign rs2_val = rf_data[RS2addr_i];

`ifdef OPFETCH_WB_BYPASS_EN
    always_comb begin
        op1_val = rs1_val;
        op2_val = ALUSrc_i ? Imm_i : rs2_val;
        if (wb_active && (WBaddr_i == RS1addr_i)) begin
            op1_val = WBdata_i;
        end
        if (!ALUSrc_i && wb_active && (WBaddr_i == RS2addr_i)) begin
            op2_val = WBdata_i;
        end
    end
`else
    assign op1_val = rs1_val;
    assign op2_val = ALUSrc_i ? Imm_i : rs2_val;
`endif

    // Flush wins over stall; reset is applied in the register process.
    always_comb begin
        valid_next = valid_reg;
        data1_next = data1_reg;
        data2_next = data2_reg;
        ctrl_next  = ctrl_reg;
        rd_next    = rd_reg;
        if (flush_i) begin
            valid_next = 1'b0;
            data1_next = 32'd0;
            data2_next = 32'd0;
            ctrl_next  = 3'd0;
            rd_next    = 5'd0;
        end else if (!stall_i) begin
            valid_next = valid_i;
            data1_next = op1_val;
            data2_next = op2_val;
            ctrl_next  = ALUCtrl_i;
            rd_next    = RDaddr_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_reg <= 1'b0;
            data1_reg <= 32'd0;
            data2_reg <= 32'd0;
            ctrl_reg  <= 3'd0;
            rd_reg    <= 5'd0;
        end else begin
            valid_reg <= valid_next;
            data1_reg <= data1_next;
            data2_reg <= data2_next;
            ctrl_reg  <= ctrl_next;
            rd_reg    <= rd_next;
        end
    end

    assign valid_o   = valid_reg;
    assign data1_o   = data1_reg;
    assign data2_o   = data2_reg;
    assign ALUCtrl_o = ctrl_reg;
    assign RDaddr_o  = rd_reg;

endmodule

// File: tb/tb_operand_fetch.sv
// Scoreboard bench for operand_fetch: directed cycles push expected outputs, a monitor pops and compares after each edge.
module tb_operand_fetch;

    logic        clk = 1'b0;
    logic        rst, valid, stall, flush, alusrc, wben;
    logic [4:0]  rs1, rs2, rd, wbaddr;
    logic [31:0] imm, wbdata;
    logic [2:0]  ctrl;
    logic        valid_o;
    logic [31:0] data1_o, data2_o;
    logic [2:0]  ctrl_o;
    logic [4:0]  rd_o;

    typedef struct {
        int          id;
        logic        v;
        logic [31:0] d1;
        logic [31:0] d2;
        logic [2:0]  c;
        logic [4:0]  r;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   fails = 0;
    int   step_id = 0;
    bit   done = 1'b0;

`ifdef OPFETCH_WB_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    always #5 clk = ~clk;

    operand_fetch dut (
        .clk_i     (clk),
        .rst_i     (rst),
        .valid_i   (valid),
        .stall_i   (stall),
        .flush_i   (flush),
        .RS1addr_i (rs1),
        .RS2addr_i (rs2),
        .RDaddr_i  (rd),
        .Imm_i     (imm),
        .ALUSrc_i  (alusrc),
        .ALUCtrl_i (ctrl),
        .WBen_i    (wben),
        .WBaddr_i  (wbaddr),
        .WBdata_i  (wbdata),
        .valid_o   (valid_o),
        .data1_o   (data1_o),
        .data2_o   (data2_o),
        .ALUCtrl_o (ctrl_o),
        .RDaddr_o  (rd_o)
    );

    task automatic idle();
        rst = 0; valid = 0; stall = 0; flush = 0; alusrc = 0; wben = 0;
        rs1 = 0; rs2 = 0; rd = 0; wbaddr = 0; imm = 0; wbdata = 0; ctrl = 0;
    endtask

    task automatic wb(input logic [4:0] a, input logic [31:0] d);
        wben = 1; wbaddr = a; wbdata = d;
    endtask

    task automatic ld(input logic v, input logic [4:0] a1, input logic [4:0] a2, input logic src,
                      input logic [31:0] im, input logic [2:0] c, input logic [4:0] r);
        valid = v; rs1 = a1; rs2 = a2; alusrc = src; imm = im; ctrl = c; rd = r;
    endtask

    // Inputs are set at a negedge; the expectation applies after the following posedge.
    task automatic go(input logic v, input logic [31:0] d1, input logic [31:0] d2,
                      input logic [2:0] c, input logic [4:0] r);
        exp_t e;
        step_id++;
        e.id = step_id; e.v = v; e.d1 = d1; e.d2 = d2; e.c = c; e.r = r;
        exp_q.push_back(e);
        @(negedge clk);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checks++;
                if (valid_o !== e.v || data1_o !== e.d1 || data2_o !== e.d2 || ctrl_o !== e.c || rd_o !== e.r) begin
                    fails++;
                    $display("FAIL step%0d: got v=%b d1=%h d2=%h c=%0d rd=%0d, want v=%b d1=%h d2=%h c=%0d rd=%0d",
                             e.id, valid_o, data1_o, data2_o, ctrl_o, rd_o, e.v, e.d1, e.d2, e.c, e.r);
                end else begin
                    $display("step%0d ok: v=%b d1=%h d2=%h c=%0d rd=%0d", e.id, valid_o, data1_o, data2_o, ctrl_o, rd_o);
                end
            end
        end
    end

    initial begin : stimulus
        idle();
        rst = 1;
        @(negedge clk);
        // 1: reset overriding a writeback and a valid load
        idle(); rst = 1; wb(5, 32'h55); ld(1, 5, 5, 0, 0, 3'd2, 5'd4);
        go(0, 0, 0, 0, 0);
        // 2: x5 was not written under reset
        idle(); ld(0, 5, 0, 0, 0, 0, 0);
        go(0, 0, 0, 0, 0);
        // 3: write x3
        idle(); wb(3, 32'hFF);
        go(0, 0, 0, 0, 0);
        // 4: read x3 on both ports while writing x0
        idle(); wb(0, 32'hDEADBEEF); ld(1, 3, 3, 0, 0, 3'b010, 5'd4);
        go(1, 32'hFF, 32'hFF, 3'b010, 5'd4);
        // 5: x0 reads zero even with a concurrent x0 write; immediate operand
        idle(); wb(0, 32'hDEADBEEF); ld(1, 0, 3, 1, 32'hFFFFFFFC, 3'b100, 5'd9);
        go(1, 0, 32'hFFFFFFFC, 3'b100, 5'd9);
        // 6: write x7 while loading a SUB
        idle(); wb(7, 32'h1111); ld(1, 3, 0, 0, 0, 3'b110, 5'd1);
        go(1, 32'hFF, 0, 3'b110, 5'd1);
        // 7-8: stall holds outputs while writeback still lands
        idle(); stall = 1; wb(10, 32'hABCD); ld(0, 7, 7, 1, 32'h5, 3'b111, 5'd31);
        go(1, 32'hFF, 0, 3'b110, 5'd1);
        idle(); stall = 1; ld(1, 10, 3, 0, 0, 3'b001, 5'd17);
        go(1, 32'hFF, 0, 3'b110, 5'd1);
        // 9: stall plus flush clears
        idle(); stall = 1; flush = 1; ld(1, 3, 3, 0, 0, 3'b010, 5'd5);
        go(0, 0, 0, 0, 0);
        // 10: x10 written during stall
        idle(); ld(1, 10, 7, 0, 0, 3'b011, 5'd2);
        go(1, 32'hABCD, 32'h1111, 3'b011, 5'd2);
        // 11: same-cycle write and read of x7
        idle(); wb(7, 32'h1234); ld(1, 7, 0, 0, 0, 3'b000, 5'd7);
        go(1, BYPASS ? 32'h1234 : 32'h1111, 0, 3'b000, 5'd7);
        // 12: invalid load still captures operands
        idle(); ld(0, 7, 7, 0, 0, 3'b001, 5'd3);
        go(0, 32'h1234, 32'h1234, 3'b001, 5'd3);
        // 13: flush alone
        idle(); flush = 1; ld(1, 7, 7, 0, 0, 3'b001, 5'd3);
        go(0, 0, 0, 0, 0);
        // 14-15: raw 32-bit patterns, no masking
        idle(); wb(12, 32'h80000001);
        go(0, 0, 0, 0, 0);
        idle(); ld(1, 12, 0, 1, 32'hFFFFFFFF, 3'b100, 5'd8);
        go(1, 32'h80000001, 32'hFFFFFFFF, 3'b100, 5'd8);
        // 16: same-cycle write on RS2 path
        idle(); wb(12, 32'h22); ld(1, 0, 12, 0, 0, 3'b010, 5'd6);
        go(1, 0, BYPASS ? 32'h22 : 32'h80000001, 3'b010, 5'd6);
        // 17: immediate selected, RS2 match must not bypass
        idle(); wb(12, 32'h33); ld(1, 0, 12, 1, 32'h5, 3'b010, 5'd6);
        go(1, 0, 32'h5, 3'b010, 5'd6);
        // 18: reset mid-operation beats stall, flush and writeback
        idle(); rst = 1; stall = 1; flush = 1; wb(3, 32'h77); ld(1, 12, 3, 0, 0, 3'b111, 5'd9);
        go(0, 0, 0, 0, 0);
        // 19: register file cleared
        idle(); ld(1, 12, 3, 0, 0, 3'b111, 5'd9);
        go(1, 0, 0, 3'b111, 5'd9);
        idle();
        repeat (3) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL drain: got %0d pending, want 0", exp_q.size());
        end
        done = 1'b1;
    end

    initial begin : finisher
        fork
            wait (done);
            begin
                repeat (2000) @(posedge clk);
                fails++;
                $display("FAIL timeout: got no completion, want completion within 2000 cycles");
            end
        join_any
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/operand_fetch.md
OPERAND_FETCH -- requirements
Module: operand_fetch

Interface
REQ-001 The block SHALL have no parameters; all widths are fixed as listed.
REQ-002 clk_i  input  1  sole clock; all state updates on rising edge.
REQ-003 rst_i  input  1  reset; synchronous, active-high.
REQ-004 valid_i  input  1  decode stage presents a valid instruction this cycle.
REQ-005 stall_i  input  1  hold the output stage registers.
REQ-006 flush_i  input  1  kill the instruction in the output stage.
REQ-007 RS1addr_i  input  5  source register 1 index.
REQ-008 RS2addr_i  input  5  source register 2 index.
REQ-009 RDaddr_i  input  5  destination index, passed through.
REQ-010 Imm_i  input  32  sign-extended immediate.
REQ-011 ALUSrc_i  input  1  1 = operand 2 is Imm_i; 0 = operand 2 is the RS2 value.
REQ-012 ALUCtrl_i  input  3  ALU operation code (AND 000, XOR 001, ADD 010, MUL 011, SRAI 100, SUB 110, SLL 111), passed through unchanged.
REQ-013 WBen_i  input  1  writeback enable.
REQ-014 WBaddr_i  input  5  writeback register index.
REQ-015 WBdata_i  input  32  writeback data.
REQ-016 valid_o  output  1  registered; operands on the outputs are valid.
REQ-017 data1_o  output  32  registered ALU operand 1.
REQ-018 data2_o  output  32  registered ALU operand 2.
REQ-019 ALUCtrl_o  output  3  registered ALU operation code.
REQ-020 RDaddr_o  output  5  registered destination index.

Function
REQ-021 The block SHALL contain a 32x32 register file; x0 reads 0 always, and writes to x0 are discarded.
REQ-022 On each edge with WBen_i=1 and WBaddr_i!=0, the block SHALL write WBdata_i into the addressed register.
REQ-023 Register-file reads SHALL be combinational and feed the output stage; RS1/RS2 data to the ALU have 1-cycle latency from the address inputs.
REQ-024 Output stage priority per edge SHALL be: rst_i, then flush_i, then stall_i, then load.
REQ-025 flush_i=1 SHALL set valid_o=0 and data1_o, data2_o, ALUCtrl_o and RDaddr_o to 0.
REQ-026 stall_i=1 (no flush) SHALL hold all output registers unchanged; the register-file write in REQ-022 SHALL still occur.
REQ-027 Load SHALL capture: data1_o = RS1 value; data2_o = Imm_i if ALUSrc_i else RS2 value; ALUCtrl_o, RDaddr_o and valid_o from the corresponding inputs.
REQ-028 With valid_i=0 on a load, the block SHALL still capture operand values, with valid_o=0.
REQ-029 Operands SHALL be stored as raw 32-bit patterns; no sign or shift-amount masking is applied (the ALU masks SRAI to [4:0]).
REQ-030 Simultaneous stall_i and flush_i SHALL behave as flush.

Reset
REQ-031 When rst_i=1 at an edge, all 32 registers SHALL clear to 0 and valid_o, data1_o, data2_o, ALUCtrl_o and RDaddr_o SHALL be 0.
REQ-032 Reset SHALL override a concurrent writeback, stall or flush, including mid-operation.

Configuration
REQ-033 With OPFETCH_WB_BYPASS_EN defined, on a load with WBen_i=1, WBaddr_i!=0 and WBaddr_i equal to RS1addr_i or RS2addr_i, the block SHALL capture WBdata_i for the matching operand (RS2 only when ALUSrc_i=0).
REQ-034 Without OPFETCH_WB_BYPASS_EN, a same-cycle read SHALL capture the old register value.

Verification
REQ-035 Reset: after rst_i=1 for one edge, a read of x5 gives data1_o=0 and valid_o=0.
REQ-036 Write then read: write x3=0x0000_00FF; next cycle RS1=3, RS2=3, ALUSrc=0, ALUCtrl=010, valid=1 -> data1_o=data2_o=0xFF, ALUCtrl_o=010, valid_o=1.
REQ-037 x0: write x0=0xDEAD_BEEF, then RS1=0 -> data1_o=0.
REQ-038 Immediate: ALUSrc=1, Imm=0xFFFF_FFFC -> data2_o=0xFFFF_FFFC.
REQ-039 Stall then flush: stall for 2 cycles with changing inputs -> outputs held; then stall+flush -> valid_o=0, all outputs 0.
REQ-040 Same-cycle write x7=0x1234 with RS1=7 -> data1_o=0x1234 when the macro is defined, otherwise the prior x7 value.
